// File: rtl/framebuf_pingpong_arbiter_pkg.sv
// Shared definitions for the ping-pong frame-buffer arbiter: state encoding and default widths.
package framebuf_pingpong_arbiter_pkg;

  localparam int unsigned FB_ADDR_WIDTH = 19;
  localparam int unsigned FB_DROP_WIDTH = 8;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_e;

endpackage

// File: rtl/framebuf_pingpong_arbiter_bank_port_mux.sv
// Steers the write-side and read-side accesses onto the two BRAM ports according to writeBank.
module framebuf_pingpong_arbiter_bank_port_mux
  import framebuf_pingpong_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  writeBank,
  input  logic                  wrWe,
  input  logic [ADDR_WIDTH-1:0] wrAddrSel,
  input  logic                  wrDataSel,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic                  RD0,
  input  logic                  RD1,
  output logic                  WE0,
  output logic                  WE1,
  output logic [ADDR_WIDTH-1:0] addrB0,
  output logic [ADDR_WIDTH-1:0] addrB1,
  output logic                  WD,
  output logic                  rdData
);

  // The read bank never sees a write strobe.
  always_comb begin
    WE0    = 1'b0;
    WE1    = 1'b0;
    addrB0 = rdAddr;
    addrB1 = rdAddr;
    WD     = wrDataSel;
    rdData = writeBank ? RD0 : RD1;
    if (writeBank) begin
      WE1    = wrWe;
      addrB1 = wrAddrSel;
    end else begin
      WE0    = wrWe;
      addrB0 = wrAddrSel;
    end
  end

endmodule

// File: rtl/framebuf_pingpong_arbiter.sv
// Ping-pong frame-buffer arbiter: clears the write bank, opens it to the writer, and swaps
// bank roles at a reader frame start once the writer has finished its frame.
module framebuf_pingpong_arbiter
  import framebuf_pingpong_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned DROP_W     = FB_DROP_WIDTH
) (
  input  logic                  TMDSclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] frameSize,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic                  wrData,
  input  logic                  wrFrameDone,
  output logic                  wrReady,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic                  rdFrameStart,
  output logic                  rdData,
  output logic                  WE0,
  output logic                  WE1,
  output logic [ADDR_WIDTH-1:0] addrB0,
  output logic [ADDR_WIDTH-1:0] addrB1,
  output logic                  WD,
  input  logic                  RD0,
  input  logic                  RD1,
  output logic                  writeBank,
  output logic [DROP_W-1:0]     dropCount
);

  fb_state_e             state_q, state_d;
  logic                  bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  ready_q;

  logic [ADDR_WIDTH-1:0] clr_last_c;
  logic                  wr_we_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic                  wr_data_c;

  // Last clear address; a zero frame size behaves as a one-pixel frame.
  assign clr_last_c = (frameSize == '0) ? '0 : frameSize - ADDR_WIDTH'(1);

  always_ff @(posedge TMDSclk) begin
    if (rst) begin
      state_q    <= CLEAR;
      bank_q     <= 1'b0;
      clr_addr_q <= '0;
      drop_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      clr_addr_q <= clr_addr_d;
      drop_q     <= drop_d;
      ready_q    <= (state_d == WRITE);
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    clr_addr_d = clr_addr_q;
    drop_d     = drop_q;
    wr_we_c    = 1'b0;
    wr_addr_c  = wrAddr;
    wr_data_c  = 1'b0;

    unique case (state_q)
      CLEAR: begin
        wr_we_c   = 1'b1;
        wr_addr_c = clr_addr_q;
        if (clr_addr_q == clr_last_c) begin
          clr_addr_d = '0;
          state_d    = WRITE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
        if (rdFrameStart && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
      end
      WRITE: begin
        wr_we_c   = wrEn;
        wr_data_c = wrData;
        if (wrFrameDone) begin
          // A coincident reader frame start swaps immediately instead of waiting.
          if (rdFrameStart) begin
            bank_d     = ~bank_q;
            clr_addr_d = '0;
            state_d    = CLEAR;
          end else begin
            state_d = WAIT_SWAP;
          end
        end else if (rdFrameStart && (drop_q != '1)) begin
          drop_d = drop_q + DROP_W'(1);
        end
      end
      WAIT_SWAP: begin
        if (rdFrameStart) begin
          bank_d     = ~bank_q;
          clr_addr_d = '0;
          state_d    = CLEAR;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase

    // No BRAM write may land while reset is being applied.
    if (rst) wr_we_c = 1'b0;
  end

  framebuf_pingpong_arbiter_bank_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank_port_mux (
    .writeBank (bank_q),
    .wrWe      (wr_we_c),
    .wrAddrSel (wr_addr_c),
    .wrDataSel (wr_data_c),
    .rdAddr    (rdAddr),
    .RD0       (RD0),
    .RD1       (RD1),
    .WE0       (WE0),
    .WE1       (WE1),
    .addrB0    (addrB0),
    .addrB1    (addrB1),
    .WD        (WD),
    .rdData    (rdData)
  );

  assign wrReady   = ready_q;
  assign writeBank = bank_q;
  assign dropCount = drop_q;

endmodule
